// File: rtl/fully_connected_if.sv
// rtl/fully_connected_if.sv - feature RAM / weight ROM bus of the fully connected layer
interface fully_connected_if #(
    parameter int memaddrbit = 14
);
    logic [memaddrbit-1:0] fmaddr;
    logic [memaddrbit-1:0] waddr;
    logic [7:0]            fc_out;
    logic                  wea;
    logic [7:0]            data_in;
    logic [7:0]            weight_in;

    // Layer engine side: drives addresses and write data, receives read data
    modport master (
        output fmaddr,
        output waddr,
        output fc_out,
        output wea,
        input  data_in,
        input  weight_in
    );

    // Memory side: returns read data two cycles after the registered address
    modport slave (
        input  fmaddr,
        input  waddr,
        input  fc_out,
        input  wea,
        output data_in,
        output weight_in
    );
endinterface

// File: rtl/fully_connected.sv
// rtl/fully_connected.sv - sequential-MAC fully connected layer with requantized 8-bit outputs
module fully_connected #(
    parameter int memaddrbit = 14,
    parameter int accbit     = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [memaddrbit-1:0] n_in,
    input  logic [memaddrbit-1:0] n_out,
    input  logic [memaddrbit-1:0] inaddr,
    input  logic [memaddrbit-1:0] weightaddr,
    input  logic [memaddrbit-1:0] outaddr,
    input  logic [3:0]            shift,
    output logic                  layer_finish,
    output logic [2:0]            state,
    fully_connected_if.master     mem
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [memaddrbit-1:0] addr_one = 1;

    state_t                  cur;
    state_t                  nxt;
    logic [memaddrbit-1:0]   k;
    logic [memaddrbit-1:0]   o;
    logic [memaddrbit-1:0]   row_base;
    logic [1:0]              dcnt;
    logic [2:0]              vpipe;
    logic signed [accbit-1:0] acc;

    logic                    last_k;
    logic                    last_o;
    logic signed [16:0]      data_ext;
    logic signed [16:0]      weight_ext;
    logic signed [16:0]      prod;
    logic signed [accbit-1:0] acc_sum;
    logic signed [accbit-1:0] shifted;
    logic [7:0]              clamped;

    assign state  = cur;
    assign last_k = (k == (n_in - addr_one));
    assign last_o = (o == (n_out - addr_one));

    // Unsigned pixel times signed weight; the 17-bit product always fits exactly
    always_comb begin
        data_ext   = {8'd0, 1'b0, mem.data_in};
        weight_ext = {{9{mem.weight_in[7]}}, mem.weight_in};
        prod       = data_ext * weight_ext;
        acc_sum    = acc + {{(accbit-17){prod[16]}}, prod};
    end

    // Requantize: arithmetic shift, then ReLU and saturate to 0..255
    always_comb begin
        shifted = acc_sum >>> shift;
        clamped = shifted[7:0];
        if (shifted[accbit-1]) begin
            clamped = 8'd0;
        end else if (|shifted[accbit-2:8]) begin
            clamped = 8'd255;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state decode; empty layers skip straight to DONE
    always_comb begin
        nxt = S_IDLE;
        case (cur)
            S_IDLE: begin
                nxt = S_IDLE;
                if (enable) begin
                    nxt = ((n_in != '0) && (n_out != '0)) ? S_MAC : S_DONE;
                end
            end
            S_MAC:   nxt = last_k ? S_DRAIN : S_MAC;
            S_DRAIN: nxt = (dcnt == 2'd2) ? S_WRITE : S_DRAIN;
            S_WRITE: nxt = last_o ? S_DONE : S_MAC;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Datapath: address issue, valid pipe, accumulator and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k            <= '0;
            o            <= '0;
            row_base     <= '0;
            dcnt         <= 2'd0;
            vpipe        <= 3'd0;
            acc          <= '0;
            mem.fmaddr   <= '0;
            mem.waddr    <= '0;
            mem.fc_out   <= 8'd0;
            mem.wea      <= 1'b0;
            layer_finish <= 1'b0;
        end else begin
            vpipe        <= {vpipe[1:0], (cur == S_MAC)};
            mem.wea      <= 1'b0;
            mem.fc_out   <= 8'd0;
            layer_finish <= (nxt == S_DONE);
            if (vpipe[2]) begin
                acc <= acc_sum;
            end
            case (cur)
                S_IDLE: begin
                    k          <= '0;
                    o          <= '0;
                    row_base   <= '0;
                    dcnt       <= 2'd0;
                    acc        <= '0;
                    mem.fmaddr <= '0;
                    mem.waddr  <= '0;
                end
                S_MAC: begin
                    mem.fmaddr <= inaddr + k;
                    mem.waddr  <= weightaddr + row_base + k;
                    k          <= last_k ? '0 : k + addr_one;
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'd2) begin
                        // Last product lands on this edge, so requantize the running sum
                        dcnt       <= 2'd0;
                        mem.fmaddr <= outaddr + o;
                        mem.wea    <= 1'b1;
                        mem.fc_out <= clamped;
                    end
                end
                S_WRITE: begin
                    acc      <= '0;
                    o        <= o + addr_one;
                    row_base <= row_base + n_in;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fully_connected.sv
// tb/tb_fully_connected.sv - scoreboard bench for the fully connected layer
module tb_fully_connected;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [AW-1:0] n_in, n_out, inaddr, weightaddr, outaddr;
    logic [3:0]    shift;
    logic          layer_finish;
    logic [2:0]    state;

    fully_connected_if #(.memaddrbit(AW)) mem ();

    fully_connected #(.memaddrbit(AW), .accbit(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .n_in         (n_in),
        .n_out        (n_out),
        .inaddr       (inaddr),
        .weightaddr   (weightaddr),
        .outaddr      (outaddr),
        .shift        (shift),
        .layer_finish (layer_finish),
        .state        (state),
        .mem          (mem.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int rel;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic cap_waddr = 1'b0;
    logic prev_mac = 1'b0;
    int   waddr_obs[$];

    logic [7:0] fm [0:1023];
    logic [7:0] wr [0:1023];
    logic [7:0] fm_d1 = 8'd0;
    logic [7:0] wr_d1 = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int addr, input int data, input int rel);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.rel  = rel;
        sbq.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle-latency memories
    always @(posedge clk) begin
        fm_d1         <= fm[mem.fmaddr[9:0]];
        mem.data_in   <= fm_d1;
        wr_d1         <= wr[mem.waddr[9:0]];
        mem.weight_in <= wr_d1;
    end

    // Monitor: every write is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (!rst) begin
            if (mem.wea) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wea: addr %0d data %0d with empty scoreboard", mem.fmaddr, mem.fc_out);
                end else begin
                    mon_e = sbq.pop_front();
                    check("wr_addr", 32'(mem.fmaddr), mon_e.addr);
                    check("wr_data", 32'(mem.fc_out), mon_e.data);
                    check("wr_cycle", cyc - t0, mon_e.rel);
                end
            end
            if (cap_waddr && prev_mac) waddr_obs.push_back(int'(mem.waddr));
        end
        prev_mac <= (state == 3'd1);
    end

    task automatic wait_finish(input int exp_rel);
        int done = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (layer_finish) begin
                done = cyc - t0;
                break;
            end
        end
        check("finish_cycle", done, exp_rel);
    endtask

    task automatic run_layer(input int nin, input int nout);
        n_in  = AW'(nin);
        n_out = AW'(nout);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        enable = 1'b0;
        wait_finish((nin == 0 || nout == 0) ? 0 : nout * (nin + 4));
        @(negedge clk);
        check("idle_after_done", 32'(state), 0);
        check("sb_drained", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        n_in = '0; n_out = '0; inaddr = '0; weightaddr = '0; outaddr = '0; shift = 4'd0;
        for (int i = 0; i < 1024; i++) begin
            fm[i] = 8'd0;
            wr[i] = 8'd0;
        end
        for (int i = 0; i < 4; i++) begin
            fm[i]     = 8'(i + 1);
            fm[4 + i] = 8'd255;
            wr[i]     = 8'd1;
            wr[4 + i] = 8'hFF;
            wr[8 + i] = 8'd127;
        end
        fm[10] = 8'd5; fm[11] = 8'd6; fm[12] = 8'd7;
        wr[20] = 8'd1; wr[21] = 8'd0; wr[22] = 8'd0;
        wr[23] = 8'd0; wr[24] = 8'd2; wr[25] = 8'd0;
        wr[26] = 8'd1; wr[27] = 8'd1; wr[28] = 8'hFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_fmaddr", 32'(mem.fmaddr), 0);
        check("rst_waddr", 32'(mem.waddr), 0);
        check("rst_wea", 32'(mem.wea), 0);
        check("rst_fc_out", 32'(mem.fc_out), 0);
        check("rst_finish", 32'(layer_finish), 0);

        // 1+2+3+4 with unit weights
        inaddr = 0; weightaddr = 0; outaddr = 100; shift = 0;
        push_exp(100, 10, 7);
        run_layer(4, 1);

        // Negative sum clamps to zero
        weightaddr = 4;
        push_exp(100, 0, 7);
        run_layer(4, 1);

        // 4*255*127 = 129540; >>>2 saturates, >>>15 gives 3
        inaddr = 4; weightaddr = 8; shift = 2;
        push_exp(100, 255, 7);
        run_layer(4, 1);
        shift = 15;
        push_exp(100, 3, 7);
        run_layer(4, 1);

        // Three neurons of three inputs: 5, 12, 5+6-7=4
        inaddr = 10; weightaddr = 20; outaddr = 200; shift = 0;
        push_exp(200, 5, 6);
        push_exp(201, 12, 13);
        push_exp(202, 4, 20);
        waddr_obs.delete();
        cap_waddr = 1'b1;
        run_layer(3, 3);
        cap_waddr = 1'b0;
        check("waddr_count", waddr_obs.size(), 9);
        for (int i = 0; i < 9 && i < waddr_obs.size(); i++) check("waddr_seq", waddr_obs[i], 20 + i);

        // Reset in the second MAC cycle aborts with no write
        inaddr = 0; weightaddr = 0; outaddr = 100; shift = 0;
        n_in = 4; n_out = 1;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_mac", 32'(state), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_fmaddr", 32'(mem.fmaddr), 0);
        check("mid_rst_waddr", 32'(mem.waddr), 0);
        check("mid_rst_wea", 32'(mem.wea), 0);
        check("mid_rst_finish", 32'(layer_finish), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_idle", 32'(state), 0);
        push_exp(100, 10, 7);
        run_layer(4, 1);

        // Enable held high: one run per IDLE visit
        push_exp(100, 10, 7);
        push_exp(100, 10, 17);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        wait_finish(8);
        @(negedge clk);
        check("held_idle_visit", 32'(state), 0);
        @(negedge clk);
        check("held_restart_mac", 32'(state), 1);
        enable = 1'b0;
        wait_finish(18);
        @(negedge clk);
        check("held_idle_end", 32'(state), 0);
        check("held_sb_drained", sbq.size(), 0);

        // Empty layer: DONE the cycle after enable, no writes
        @(negedge clk);
        n_in = 4; n_out = 0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        enable = 1'b0;
        check("empty_done_state", 32'(state), 4);
        check("empty_finish", 32'(layer_finish), 1);
        @(negedge clk);
        @(negedge clk);
        check("empty_idle", 32'(state), 0);
        check("empty_finish_low", 32'(layer_finish), 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fully_connected.md
# fully_connected

Downstream consumer of the max-pooling stage: reads the pooled feature map from the shared feature RAM, multiplies it against an 8-bit signed weight ROM, and writes one requantized 8-bit activation per output neuron back to the feature RAM. Computes one neuron at a time with a single sequential MAC, then raises `layer_finish` for the top-level sequencer.

## Interface
- `memaddrbit`, 14, width of all address and size signals
- `accbit`, 24, signed accumulator width (≥ 17)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  start request, sampled only in IDLE
- `n_in`  in  memaddrbit  inputs per neuron (pooled map size)
- `n_out`  in  memaddrbit  number of output neurons
- `inaddr`  in  memaddrbit  feature RAM base of input vector
- `weightaddr`  in  memaddrbit  weight ROM base, row-major (neuron o, input k at `o*n_in+k`)
- `outaddr`  in  memaddrbit  feature RAM base of output vector
- `shift`  in  4  arithmetic right shift for requantization
- `data_in`  in  8  feature RAM read data, unsigned
- `weight_in`  in  8  weight ROM read data, signed two's complement
- `fmaddr`  out  memaddrbit  feature RAM address (read and write), registered
- `waddr`  out  memaddrbit  weight ROM address, registered
- `fc_out`  out  8  write data, valid when `wea`=1, else 0
- `wea`  out  1  feature RAM write enable
- `layer_finish`  out  1  high for exactly the DONE cycle
- `state`  out  3  current FSM state

## Operation
- States: IDLE=0, MAC=1, DRAIN=2, WRITE=3, DONE=4; unused encodings → IDLE.
- IDLE: `enable`=1 → MAC if `n_in`≠0 and `n_out`≠0, else → DONE (no reads, no writes). Output index o and issue index k cleared.
- MAC: one issue per cycle, k = 0..n_in-1; next edge registers `fmaddr`=inaddr+k, `waddr`=weightaddr+o*n_in+k. After k=n_in-1 → DRAIN.
- 3-stage valid pipe tracks issues; data for issue k is accumulated at the edge ending the 3rd cycle after its issue cycle (1 cycle address register + 2 cycles memory latency).
- Accumulate: acc ← acc + {0,data_in} × sign(weight_in), 17-bit signed product sign-extended to `accbit`; acc wraps, never saturates internally.
- acc cleared on entry to MAC (from IDLE or WRITE).
- DRAIN: exactly 3 cycles; on the edge ending the last DRAIN cycle, `fmaddr` ← outaddr+o.
- WRITE: 1 cycle, `wea`=1, `fc_out`=clamp(acc >>> shift, 0, 255) (ReLU + saturate). Then o = n_out-1 → DONE, else o++, → MAC.
- DONE: `layer_finish`=1 for one cycle, → IDLE.
- `enable` outside IDLE ignored. All address sums truncate modulo 2^memaddrbit.
- `fmaddr`, `waddr` hold last value outside MAC/DRAIN; return to 0 in IDLE.

## Timing
- Reset: state IDLE, acc/o/k/valid pipe 0, `fmaddr`=`waddr`=0, `wea`=0, `fc_out`=0, `layer_finish`=0.
- Reset mid-operation: immediate return to IDLE, pending pipe data discarded, no further writes.
- `enable` sampled at edge E0 → first MAC cycle is the next cycle.
- Per neuron: n_in (MAC) + 3 (DRAIN) + 1 (WRITE) = n_in+4 cycles.
- Layer latency from first MAC cycle to DONE: n_out*(n_in+4) cycles; IDLE re-entered one cycle later.
- `wea`, `fc_out`, `layer_finish` are decoded from registered state/acc; no combinational path from inputs.

## Test plan
- n_in=4, n_out=1, data 1,2,3,4, weights 1,1,1,1, shift 0, enable at cycle 0 → MAC cycles 1–4, DRAIN 5–7, WRITE cycle 8 with `wea`=1, `fmaddr`=outaddr, `fc_out`=10; `layer_finish` cycle 9; IDLE cycle 10.
- Same data, weights -1 ×4 → acc=-10, `fc_out`=0 (ReLU clamp).
- data 255 ×4, weights 127 ×4, shift 2 → acc=129540, >>>2 = 32385 → `fc_out`=255; shift 15 → `fc_out`=3.
- n_in=3, n_out=3 → `waddr` sequence weightaddr+0..8, three `wea` pulses 7 cycles apart at outaddr, +1, +2, per-neuron results independent (acc cleared between neurons).
- Assert `rst` during second MAC cycle → outputs at reset values immediately, no `wea`; re-enable → correct full result.
- `enable` held high throughout a layer → exactly one layer run per IDLE visit; n_out=0 → DONE cycle after enable, no `wea`, `layer_finish` pulse.
